// File: rtl/jtag_tms_sequencer_pkg.sv
// jtag_tms_sequencer_pkg: FSM encoding, START busy-wait limit and clog2 helper
// shared by the TMS sequencer and its command FIFO.
package jtag_tms_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } seq_state_t;

    localparam int START_BUSY_LIMIT = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtag_cmd_fifo.sv
// jtag_cmd_fifo: synchronous command FIFO with occupancy count and a flush that
// empties it in a single cycle. Callers only assert wr_en/rd_en when legal.
module jtag_cmd_fifo
    import jtag_tms_sequencer_pkg::*;
#(
    parameter int pWIDTH = 20,
    parameter int pDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [pWIDTH-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic                      flush,
    output logic [pWIDTH-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(pDEPTH):0]    count
);

    localparam int AW = clog2(pDEPTH);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(pDEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/jtag_tms_sequencer.sv
// jtag_tms_sequencer: pops TMS pattern commands from a small FIFO and replays each
// one repeat+1 times through the bit-banger go/busy/done handshake.
module jtag_tms_sequencer
    import jtag_tms_sequencer_pkg::*;
#(
    parameter int pPATTERN_WIDTH = 16,
    parameter int pFIFO_DEPTH    = 4,
    parameter int pREPEAT_WIDTH  = 4,
    parameter int pTIMEOUT       = 65535
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [pPATTERN_WIDTH-1:0]     cmd_pattern,
    input  logic [pREPEAT_WIDTH-1:0]      cmd_repeat,
    input  logic                          cmd_wr,
    output logic                          cmd_full,
    output logic [clog2(pFIFO_DEPTH):0]   cmd_count,
    input  logic                          flush,
    output logic [pPATTERN_WIDTH-1:0]     bb_pattern,
    output logic                          bb_go,
    input  logic                          bb_busy,
    input  logic                          bb_done,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic                          err_timeout,
    output logic                          err_overflow,
    input  logic                          err_clear
);

    localparam int EW = pPATTERN_WIDTH + pREPEAT_WIDTH;
    localparam int TW = (clog2(pTIMEOUT + 1) > 3) ? clog2(pTIMEOUT + 1) : 3;

    seq_state_t                state_q, state_d;
    logic [pPATTERN_WIDTH-1:0] pattern_q, pattern_d;
    logic [pREPEAT_WIDTH-1:0]  rep_cnt_q, rep_cnt_d;
    logic [TW-1:0]             tcnt_q, tcnt_d;
    logic                      again_q, again_d;
    logic                      flushed_q, flushed_d;
    logic                      err_timeout_q, err_timeout_d;
    logic                      err_overflow_q, err_overflow_d;
    logic [EW-1:0]             fifo_head;
    logic                      fifo_empty, fifo_full;
    logic                      pop, push, overflow, timeout_evt;

    // A full FIFO still accepts a write in the cycle the head is popped.
    assign pop      = (state_q == ST_IDLE) && !fifo_empty && !flush;
    assign push     = cmd_wr && !flush && (!fifo_full || pop);
    assign overflow = cmd_wr && !flush && fifo_full && !pop;

    jtag_cmd_fifo #(
        .pWIDTH (EW),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data ({cmd_pattern, cmd_repeat}),
        .rd_en   (pop),
        .flush   (flush),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (cmd_count)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        rep_cnt_d   = rep_cnt_q;
        tcnt_d      = tcnt_q + TW'(1);
        again_d     = again_q;
        flushed_d   = 1'b0;
        timeout_evt = 1'b0;
        bb_go       = 1'b0;
        seq_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (pop) begin
                    state_d   = ST_START;
                    pattern_d = fifo_head[EW-1:pREPEAT_WIDTH];
                    rep_cnt_d = fifo_head[pREPEAT_WIDTH-1:0];
                end
            end
            ST_START: begin
                bb_go = !flush;
                if (bb_busy) begin
                    state_d = ST_WAIT_DONE;
                    tcnt_d  = '0;
                end else if (tcnt_q == TW'(START_BUSY_LIMIT - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_GAP;
                    again_d     = 1'b0;
                    rep_cnt_d   = '0;
                end
            end
            ST_WAIT_DONE: begin
                if (bb_done) begin
                    state_d = ST_GAP;
                    again_d = (rep_cnt_q != '0);
                    if (again_d) rep_cnt_d = rep_cnt_q - pREPEAT_WIDTH'(1);
                end else if (tcnt_q == TW'(pTIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_GAP;
                    again_d     = 1'b0;
                    rep_cnt_d   = '0;
                end
            end
            ST_GAP: begin
                tcnt_d   = '0;
                state_d  = again_q ? ST_START : ST_IDLE;
                seq_done = !again_q && !flushed_q && !flush && fifo_empty;
            end
        endcase
        // Flush aborts the active command; the GAP it lands in must not report completion.
        if (flush) begin
            rep_cnt_d   = '0;
            again_d     = 1'b0;
            timeout_evt = 1'b0;
            flushed_d   = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
            state_d     = flushed_d ? ST_GAP : ST_IDLE;
        end
        err_timeout_d  = timeout_evt || (err_timeout_q && !err_clear);
        err_overflow_d = overflow || (err_overflow_q && !err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            pattern_q      <= '0;
            rep_cnt_q      <= '0;
            tcnt_q         <= '0;
            again_q        <= 1'b0;
            flushed_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            rep_cnt_q      <= rep_cnt_d;
            tcnt_q         <= tcnt_d;
            again_q        <= again_d;
            flushed_q      <= flushed_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign cmd_full     = fifo_full;
    assign bb_pattern   = pattern_q;
    assign seq_busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: doc/jtag_tms_sequencer.md
Name: jtag_tms_sequencer

Overview:
Command-queue controller that sequences the TMS bit-banger used to drive JTAG state changes and JTAG-to-SWD switch/line-reset sequences on the target debug port. Software pushes TMS pattern commands into a small FIFO. The sequencer pops each command, replays it the requested number of times through the bit-banger go/busy/done handshake, and reports completion and errors. It sits between the register interface and the bit-banger instance in the trace/debug top level.

Parameters:
pPATTERN_WIDTH, 16, TMS pattern bits per command; must match the bit-banger instance.
pFIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
pREPEAT_WIDTH, 4, width of the per-command repeat field; a command runs repeat+1 times.
pTIMEOUT, 65535, max cycles in WAIT_DONE before an abort.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cmd_pattern  input  pPATTERN_WIDTH  TMS pattern to enqueue
cmd_repeat  input  pREPEAT_WIDTH  extra repetitions for this command
cmd_wr  input  1  enqueue strobe, one entry per cycle high
cmd_full  output  1  FIFO full
cmd_count  output  clog2(pFIFO_DEPTH)+1  entries queued
flush  input  1  drop queued commands and abort the active one
bb_pattern  output  pPATTERN_WIDTH  pattern to the bit-banger, held stable while running
bb_go  output  1  bit-banger start request
bb_busy  input  1  bit-banger busy
bb_done  input  1  bit-banger done, one-cycle pulse
seq_busy  output  1  high when not IDLE or FIFO non-empty
seq_done  output  1  one-cycle pulse when the FIFO drains to empty after the last command
err_timeout  output  1  sticky timeout error
err_overflow  output  1  sticky error: cmd_wr while full
err_clear  input  1  clears both sticky errors

Behaviour:
Reset (async assert, sync release): FIFO empty, state IDLE. All outputs 0, including bb_pattern and cmd_count.
- FIFO: write when cmd_wr && !cmd_full. A write while full is dropped and sets err_overflow.
- Simultaneous write and pop on a full FIFO is legal and keeps the count unchanged.
- Pointers wrap modulo pFIFO_DEPTH.

State machine:
- IDLE: if FIFO non-empty, pop the head into the pattern/repeat registers, set rep_cnt=repeat, go to START. Popping takes one cycle.
- START: bb_go=1. When bb_busy is sampled high, drop bb_go the next cycle and go to WAIT_DONE. bb_go is never held through done, so the bit-banger cannot double-start.
- START exit: if bb_busy is not seen within 8 cycles, set err_timeout and go to GAP.
- WAIT_DONE: a timeout counter counts cycles.
  - On bb_done: if rep_cnt != 0, decrement it and go to GAP, then START with the same pattern.
  - On bb_done with rep_cnt == 0: go to GAP, then IDLE.
  - If the counter reaches pTIMEOUT: set err_timeout, clear rep_cnt, go to GAP.
- GAP: exactly one cycle with bb_go=0. This lets the bit-banger clear its done flag before the next go.
- seq_done: pulses in the GAP→IDLE transition cycle when the FIFO is empty.

Boundary and simultaneous events:
- flush: the FIFO empties the same cycle and rep_cnt clears.
  - From START or WAIT_DONE, drop bb_go and go to GAP, then IDLE.
  - seq_done does not pulse on a flush.
  - A bit-banger pattern already in flight completes on the wire; its done pulse is ignored.
- cmd_wr in the same cycle as flush: the write is discarded.
- err_clear in the same cycle as a new error: the error wins and stays set.
- repeat=0: the command runs exactly once. The maximum repeat runs 2^pREPEAT_WIDTH times.
- Reset mid-sequence: everything returns to reset values immediately. bb_go=0 asynchronously.

Decomposition:
- Shared package: state encoding constants (IDLE, START, WAIT_DONE, GAP), the START busy-wait limit (8), and the clog2 helper.
- One sub-module: jtag_cmd_fifo. It is a synchronous FIFO of width pPATTERN_WIDTH+pREPEAT_WIDTH with full, empty, count and flush.
- The FSM, repeat counter, timeout counter and error flags stay in the top module.

Test Plan:
- Single command: pattern 0x00FF, repeat 0 → one bb_go rising edge, bb_pattern=0x00FF stable until done, then seq_done pulses once and seq_busy falls.
- Repeat: pattern 0xFFFF, repeat 3 → exactly 4 go/busy/done handshakes, each separated by ≥1 cycle with bb_go=0, then one seq_done.
- Queue ordering and overflow: write 0x1111, 0x2222, 0x3333, 0x4444, then a fifth write with the FIFO full.
  - The fifth write sets err_overflow and cmd_count stays 4.
  - Patterns are issued in order 1111, 2222, 3333, 4444.
  - err_clear then drops the flag.
- Timeout: a bit-banger model that never asserts done, with pTIMEOUT=100 → err_timeout sets at cycle 100 of WAIT_DONE, the FSM returns to IDLE, and the next queued command still runs.
- Flush mid-run: queue 3 commands and assert flush during the first WAIT_DONE.
  - cmd_count goes to 0 the next cycle and bb_go stays 0.
  - No seq_done pulses and the late bb_done is ignored.
- Async reset during the START state → bb_go, seq_busy and cmd_count are 0 before the next clk edge. After release the FSM is in IDLE with an empty FIFO.
